// File: rtl/axi_wr_arbiter_if.sv
// AXI write-channel bundle (AW, W, B) shared by the arbiter's master ports and its slave port.
interface axi_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [ID_WIDTH-1:0]       awid;
  logic [3:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic [ID_WIDTH-1:0]       bid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin AXI write arbiter; one transaction owns the slave from AW accept to B handshake.
module axi_wr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_wr_arbiter_if.slave  m0,
  axi_wr_arbiter_if.slave  m1,
  axi_wr_arbiter_if.master s,
  output logic [1:0]       grant,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;    // 1: m1 was the most recent owner
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;

  logic own0, own1;
  logic in_addr, in_data, in_resp;
  logic aw_fire, w_fire, b_fire;

  logic                    sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic [ADDR_WIDTH-1:0]   sel_awaddr;
  logic [ID_WIDTH-1:0]     sel_awid;
  logic [3:0]              sel_awlen;
  logic [2:0]              sel_awsize;
  logic [1:0]              sel_awburst;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;
  logic                    s_awvalid, s_wvalid, s_bready;

  assign own0    = grant_q[0];
  assign own1    = grant_q[1];
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);

  always_comb begin
    sel_awvalid = own1 ? m1.awvalid : m0.awvalid;
    sel_awaddr  = own1 ? m1.awaddr  : m0.awaddr;
    sel_awid    = own1 ? m1.awid    : m0.awid;
    sel_awlen   = own1 ? m1.awlen   : m0.awlen;
    sel_awsize  = own1 ? m1.awsize  : m0.awsize;
    sel_awburst = own1 ? m1.awburst : m0.awburst;
    sel_wvalid  = own1 ? m1.wvalid  : m0.wvalid;
    sel_wdata   = own1 ? m1.wdata   : m0.wdata;
    sel_wstrb   = own1 ? m1.wstrb   : m0.wstrb;
    sel_wlast   = own1 ? m1.wlast   : m0.wlast;
    sel_bready  = own1 ? m1.bready  : m0.bready;
  end

  // Slave-side valids/ready are qualified by state so nothing leaks outside the owning phase.
  assign s_awvalid = in_addr & sel_awvalid;
  assign s_wvalid  = in_data & sel_wvalid;
  assign s_bready  = in_resp & sel_bready;

  assign s.awvalid = s_awvalid;
  assign s.awaddr  = sel_awaddr;
  assign s.awid    = sel_awid;
  assign s.awlen   = sel_awlen;
  assign s.awsize  = sel_awsize;
  assign s.awburst = sel_awburst;
  assign s.wvalid  = s_wvalid;
  assign s.wdata   = sel_wdata;
  assign s.wstrb   = sel_wstrb;
  assign s.wlast   = sel_wlast;
  assign s.bready  = s_bready;

  assign m0.awready = in_addr & own0 & s.awready;
  assign m0.wready  = in_data & own0 & s.wready;
  assign m0.bvalid  = in_resp & own0 & s.bvalid;
  assign m0.bresp   = own0 ? s.bresp : '0;
  assign m0.bid     = own0 ? s.bid   : '0;

  assign m1.awready = in_addr & own1 & s.awready;
  assign m1.wready  = in_data & own1 & s.wready;
  assign m1.bvalid  = in_resp & own1 & s.bvalid;
  assign m1.bresp   = own1 ? s.bresp : '0;
  assign m1.bid     = own1 ? s.bid   : '0;

  assign aw_fire = s_awvalid & s.awready;
  assign w_fire  = s_wvalid & s.wready;
  assign b_fire  = s.bvalid & s_bready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0.awvalid | m1.awvalid) begin
          if (m0.awvalid & m1.awvalid) grant_d = last_q ? 2'b01 : 2'b10;
          else                         grant_d = m1.awvalid ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_fire) begin
          len_d   = sel_awlen;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Burst ends on wlast or once awlen+1 beats have been accepted, whichever comes first.
        if (w_fire) begin
          cnt_d = cnt_q + 4'd1;
          if (sel_wlast || (cnt_q == len_q)) state_d = RESP;
        end
      end
      RESP: begin
        if (b_fire) begin
          last_d  = own1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: randomized two-master traffic against a transaction-level order model.
module tb_axi_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LIMIT = 500;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          offered;
    int          lastpos;
    int          bdelay;
    logic [31:0] salt;
    int          nbeats;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_if [2] ();
  axi_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();
  logic [1:0] grant;
  logic       busy;

  axi_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m_if[0]), .m1(m_if[1]), .s(s_if), .grant(grant), .busy(busy)
  );

  logic          awvalid_m [2];
  logic [AW-1:0] awaddr_m  [2];
  logic [IW-1:0] awid_m    [2];
  logic [3:0]    awlen_m   [2];
  logic [2:0]    awsize_m  [2];
  logic [1:0]    awburst_m [2];
  logic          wvalid_m  [2];
  logic [DW-1:0] wdata_m   [2];
  logic [DW/8-1:0] wstrb_m [2];
  logic          wlast_m   [2];
  logic          bready_m  [2];
  logic          awready_m [2];
  logic          wready_m  [2];
  logic          bvalid_m  [2];
  logic [1:0]    bresp_m   [2];
  logic [IW-1:0] bid_m     [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign m_if[g].awvalid = awvalid_m[g];
    assign m_if[g].awaddr  = awaddr_m[g];
    assign m_if[g].awid    = awid_m[g];
    assign m_if[g].awlen   = awlen_m[g];
    assign m_if[g].awsize  = awsize_m[g];
    assign m_if[g].awburst = awburst_m[g];
    assign m_if[g].wvalid  = wvalid_m[g];
    assign m_if[g].wdata   = wdata_m[g];
    assign m_if[g].wstrb   = wstrb_m[g];
    assign m_if[g].wlast   = wlast_m[g];
    assign m_if[g].bready  = bready_m[g];
    assign awready_m[g]    = m_if[g].awready;
    assign wready_m[g]     = m_if[g].wready;
    assign bvalid_m[g]     = m_if[g].bvalid;
    assign bresp_m[g]      = m_if[g].bresp;
    assign bid_m[g]        = m_if[g].bid;
  end

  logic          s_awready, s_wready, s_bvalid;
  logic [1:0]    s_bresp;
  logic [IW-1:0] s_bid;
  assign s_if.awready = s_awready;
  assign s_if.wready  = s_wready;
  assign s_if.bvalid  = s_bvalid;
  assign s_if.bresp   = s_bresp;
  assign s_if.bid     = s_bid;

  int   errors = 0;
  int   checks = 0;
  txn_t exp_q [$];
  int   last_served = 1;
  bit   slave_fast = 1'b0;
  bit   abort = 1'b0;
  txn_t cur;
  bit   cur_valid = 1'b0;
  int   sbeats = 0;
  int   mw_cnt [2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input txn_t t, input int b);
    return t.salt ^ (32'(b) * 32'h0101_0101) ^ {t.id, 28'h0};
  endfunction

  function automatic logic [3:0] beat_strb(input txn_t t, input int b);
    return t.salt[3:0] ^ 4'(b);
  endfunction

  function automatic txn_t mk(input int m, input int len, input int extra, input int lastpos, input int bdelay);
    txn_t t;
    t.m       = m;
    t.addr    = $urandom;
    t.id      = 4'($urandom_range(0, 15));
    t.len     = 4'(len);
    t.burst   = 2'($urandom_range(0, 2));
    t.offered = len + 1 + extra;
    t.lastpos = lastpos;
    t.bdelay  = bdelay;
    t.salt    = $urandom;
    t.nbeats  = (lastpos + 1 < len + 1) ? lastpos + 1 : len + 1;
    return t;
  endfunction

  function automatic txn_t mk_rand(input int m);
    int len, extra, lp;
    len   = $urandom_range(0, 7);
    extra = $urandom_range(0, 2);
    lp    = ($urandom_range(0, 2) == 0) ? 99 : $urandom_range(0, len + extra);
    return mk(m, len, extra, lp, $urandom_range(0, 3));
  endfunction

  task automatic master_run(input txn_t t);
    int m, guard, b, bseen;
    bit wf, bf, done;
    m = t.m;
    @(negedge clk);
    awvalid_m[m] = 1'b1; awaddr_m[m] = t.addr; awid_m[m] = t.id;
    awlen_m[m] = t.len; awsize_m[m] = 3'd2; awburst_m[m] = t.burst;
    guard = 0;
    #1;
    while (!awready_m[m] && !abort && guard < LIMIT) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= LIMIT) chk("aw_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    awvalid_m[m] = 1'b0;
    done = abort || (guard >= LIMIT);
    b = 0; bseen = 0; guard = 0;
    while (!done) begin
      wvalid_m[m] = (b < t.offered);
      wdata_m[m]  = beat_data(t, b);
      wstrb_m[m]  = beat_strb(t, b);
      wlast_m[m]  = (b == t.lastpos);
      bready_m[m] = (bseen >= t.bdelay);
      #1;
      wf = wvalid_m[m] && wready_m[m];
      bf = bvalid_m[m] && bready_m[m];
      if (bvalid_m[m] && !bready_m[m]) bseen++;
      @(negedge clk);
      if (wf) b++;
      guard++;
      if (bf || abort) done = 1'b1;
      else if (guard >= LIMIT) begin
        chk("wb_timeout", 64'(guard), 64'd0);
        done = 1'b1;
      end
    end
    wvalid_m[m] = 1'b0; wlast_m[m] = 1'b0; bready_m[m] = 1'b0;
  endtask

  // Reference order: a lone requester is served; with both requesting, the one not served last goes first.
  task automatic run_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
    if (r0 && r1) begin
      if (last_served == 1) begin exp_q.push_back(t0); exp_q.push_back(t1); last_served = 1; end
      else                  begin exp_q.push_back(t1); exp_q.push_back(t0); last_served = 0; end
    end else if (r0) begin
      exp_q.push_back(t0); last_served = 0;
    end else begin
      exp_q.push_back(t1); last_served = 1;
    end
    fork
      begin if (r0) master_run(t0); end
      begin if (r1) master_run(t1); end
    join
    #2;
    chk("idle_after_round", {62'd0, grant}, 64'd0);
    chk("busy_after_round", 64'(busy), 64'd0);
  endtask

  // Slave model: accepts AW/W with random stalls, answers B with bid=awid and bresp=awid[1:0].
  initial begin : slave_bfm
    bit awf, bf, pend;
    logic [IW-1:0] pid, awid_s;
    awf = 0; bf = 0; pend = 0; pid = '0; awid_s = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; awf = 0; bf = 0;
        s_bvalid = 0; s_awready = 0; s_wready = 0;
        continue;
      end
      if (bf) begin s_bvalid = 0; pend = 0; end
      if (awf) begin pend = 1; pid = awid_s; end
      if (pend && !s_bvalid && (slave_fast || $urandom_range(0, 2) == 0)) begin
        s_bvalid = 1; s_bid = pid; s_bresp = pid[1:0];
      end
      s_awready = slave_fast || ($urandom_range(0, 3) != 0);
      s_wready  = slave_fast || ($urandom_range(0, 3) != 0);
      #1;
      awf    = s_if.awvalid && s_awready;
      awid_s = s_if.awid;
      bf     = s_bvalid && s_if.bready;
    end
  end

  initial begin : monitor
    int o;
    mw_cnt[0] = 0; mw_cnt[1] = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        cur_valid = 0; sbeats = 0; mw_cnt[0] = 0; mw_cnt[1] = 0;
        continue;
      end
      if (cur_valid) begin
        o = 1 - cur.m;
        chk("busy_hold", 64'(busy), 64'd1);
        chk("nonowner_hs", {61'd0, awready_m[o], wready_m[o], bvalid_m[o]}, 64'd0);
      end
      if (s_if.awvalid && s_if.awready) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          cur = exp_q.pop_front();
          cur_valid = 1; sbeats = 0;
          chk("aw_fields", {19'd0, s_if.awaddr, s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst},
                           {19'd0, cur.addr, cur.id, cur.len, 3'd2, cur.burst});
          chk("aw_grant", {62'd0, grant}, 64'(1 << cur.m));
        end
      end
      for (int n = 0; n < 2; n++) if (wvalid_m[n] && wready_m[n]) mw_cnt[n]++;
      if (s_if.wvalid && s_if.wready) begin
        if (!cur_valid) chk("w_unexpected", 64'd1, 64'd0);
        else begin
          chk("w_extra", 64'(sbeats < cur.nbeats), 64'd1);
          chk("w_beat", {27'd0, s_if.wdata, s_if.wstrb, s_if.wlast},
                        {27'd0, beat_data(cur, sbeats), beat_strb(cur, sbeats), sbeats == cur.lastpos});
          chk("w_grant", {62'd0, grant}, 64'(1 << cur.m));
          sbeats++;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (bvalid_m[n] && bready_m[n]) begin
          if (!cur_valid) chk("b_unexpected", 64'd1, 64'd0);
          else begin
            chk("b_owner", 64'(n), 64'(cur.m));
            chk("b_id_resp", {58'd0, bid_m[n], bresp_m[n]}, {58'd0, cur.id, cur.id[1:0]});
            chk("beats_fwd", 64'(sbeats), 64'(cur.nbeats));
            chk("beats_acc", 64'(mw_cnt[n]), 64'(cur.nbeats));
          end
          cur_valid = 0; mw_cnt[n] = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    txn_t t0, t1;
    int k, g;
    for (int i = 0; i < 2; i++) begin
      awvalid_m[i] = 0; awaddr_m[i] = '0; awid_m[i] = '0; awlen_m[i] = '0; awsize_m[i] = '0;
      awburst_m[i] = '0; wvalid_m[i] = 0; wdata_m[i] = '0; wstrb_m[i] = '0; wlast_m[i] = 0; bready_m[i] = 0;
    end
    // Requests held during reset must not produce any handshake output.
    awvalid_m[0] = 1; wvalid_m[0] = 1; bready_m[0] = 1; bready_m[1] = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {52'd0, awready_m[0], wready_m[0], bvalid_m[0], awready_m[1], wready_m[1], bvalid_m[1],
                          s_if.awvalid, s_if.wvalid, s_if.bready, grant, busy}, 64'd0);
    awvalid_m[0] = 0; wvalid_m[0] = 0; bready_m[0] = 0; bready_m[1] = 0;
    @(negedge clk); rst_n = 1;

    run_round(1, 1, mk(0, 2, 0, 2, 0), mk(1, 1, 0, 1, 1));
    run_round(1, 1, mk(0, 0, 1, 99, 0), mk(1, 3, 0, 99, 2));
    slave_fast = 1;
    run_round(1, 0, mk(0, 3, 0, 3, 0), mk(1, 0, 0, 0, 0));
    run_round(0, 1, mk(0, 0, 0, 0, 0), mk(1, 1, 1, 99, 0));
    slave_fast = 0;
    run_round(1, 1, mk(0, 2, 0, 99, 5), mk(1, 1, 0, 1, 0));
    run_round(1, 0, mk(0, 4, 2, 1, 0), mk(1, 0, 0, 0, 0));

    for (int r = 0; r < 40; r++) begin
      slave_fast = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 2);
      run_round(k != 1, k != 0, mk_rand(0), mk_rand(1));
    end

    // Asynchronous reset in the middle of a 4-beat burst.
    slave_fast = 1;
    t0 = mk(0, 3, 0, 3, 0);
    exp_q.push_back(t0);
    fork master_run(t0); join_none
    g = 0;
    while (!(cur_valid && sbeats == 1) && g < LIMIT) begin @(negedge clk); #3; g++; end
    if (g >= LIMIT) chk("midburst_timeout", 64'(g), 64'd0);
    rst_n = 0;
    #1;
    chk("midburst_reset_out", {52'd0, awready_m[0], wready_m[0], bvalid_m[0], awready_m[1], wready_m[1], bvalid_m[1],
                               s_if.awvalid, s_if.wvalid, s_if.bready, grant, busy}, 64'd0);
    abort = 1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    last_served = 1;
    abort = 0;
    @(negedge clk); rst_n = 1;
    slave_fast = 0;
    repeat (4) @(negedge clk);
    run_round(1, 1, mk(0, 1, 0, 99, 0), mk(1, 2, 1, 99, 0));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
